// File: rtl/reuleaux_pkg.sv
// Shared definitions for the Reuleaux triangle sequencer.
// Holds the screen geometry, the fixed-point sqrt(3) constants used for the
// arc centres, the controller state type and the coordinate saturation helpers.
package reuleaux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // d*sqrt(3)/6 ~= (d*296)>>10 and d*sqrt(3)/3 ~= (d*591)>>10
    localparam int K_SQ3_6 = 296;
    localparam int K_SQ3_3 = 591;
    localparam int K_SHIFT = 10;

    typedef enum logic [3:0] {
        IDLE,
        LATCH,
        CLEAR,
        C1_RUN,
        C1_ACK,
        C2_RUN,
        C2_ACK,
        C3_RUN,
        C3_ACK,
        DONE
    } state_t;

    // Clamp an 11-bit signed x coordinate into the signed 9-bit range.
    function automatic logic signed [8:0] sat_x(input logic signed [10:0] v);
        if (v > 11'sd255) begin
            return 9'sd255;
        end else if (v < -11'sd256) begin
            return -9'sd256;
        end
        return v[8:0];
    endfunction

    // Clamp an 11-bit signed y coordinate into the signed 8-bit range.
    function automatic logic signed [7:0] sat_y(input logic signed [10:0] v);
        if (v > 11'sd127) begin
            return 8'sd127;
        end else if (v < -11'sd128) begin
            return -8'sd128;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/reuleaux_if.sv
// Request/pixel bus between the lab top level and reuleaux_ctrl.
//   master : drives start, centre_x, centre_y, diameter, colour;
//            observes done and the VGA pixel-write port.
//   slave  : the controller side of the same signals.
interface reuleaux_if;

    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] diameter;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output start, centre_x, centre_y, diameter, colour,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, centre_x, centre_y, diameter, colour,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/circle.sv
// Midpoint circle engine that emits one 60-degree arc of a circle.
// One candidate pixel per cycle (eight octant reflections per iteration);
// pixels outside the arc's sector or outside the 8-bit/7-bit output range
// are not plotted.  done stays high until start is released.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : level request
//   centre_x/centre_y  : signed circle centre
//   radius             : unsigned radius
//   done               : arc complete
//   vga_x/vga_y/plot   : candidate pixel and its write strobe
module circle #(
    parameter int SEGMENT_TYPE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic signed [8:0] centre_x,
    input  logic signed [7:0] centre_y,
    input  logic        [8:0] radius,
    output logic              done,
    output logic        [7:0] vga_x,
    output logic        [6:0] vga_y,
    output logic              vga_plot
);

    typedef enum logic [1:0] {E_IDLE, E_PLOT, E_FIN} eng_state_t;

    eng_state_t         state, state_next;
    logic signed [10:0] off_x, off_y, step_x, step_y, next_x;
    logic signed [11:0] crit, crit_a, crit_b;
    logic        [2:0]  octant;
    logic signed [10:0] dx, dy, px, py;
    logic signed [21:0] dx_w, dy_w, dx_sq3, dy_sq;
    logic               finish, in_range, in_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= E_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_x  <= '0;
            off_y  <= '0;
            crit   <= '0;
            octant <= '0;
        end else if (state == E_IDLE && start) begin
            off_x  <= $signed({2'b00, radius});
            off_y  <= '0;
            crit   <= 12'sd1 - $signed({3'b000, radius});
            octant <= '0;
        end else if (state == E_PLOT) begin
            octant <= octant + 3'd1;
            if (octant == 3'd7) begin
                off_y <= step_y;
                off_x <= next_x;
                crit  <= (crit <= 12'sd0) ? crit_a : crit_b;
            end
        end
    end

    always_comb begin
        step_y = off_y + 11'sd1;
        step_x = off_x - 11'sd1;
        next_x = (crit <= 12'sd0) ? off_x : step_x;
        crit_a = crit + $signed({step_y, 1'b1});
        crit_b = crit + $signed({step_y - step_x, 1'b1});
        finish = (octant == 3'd7) && (step_y > next_x);

        dx = off_x;
        dy = off_y;
        case (octant)
            3'd0: begin dx =  off_x; dy =  off_y; end
            3'd1: begin dx =  off_y; dy =  off_x; end
            3'd2: begin dx = -off_x; dy =  off_y; end
            3'd3: begin dx = -off_y; dy =  off_x; end
            3'd4: begin dx =  off_x; dy = -off_y; end
            3'd5: begin dx =  off_y; dy = -off_x; end
            3'd6: begin dx = -off_x; dy = -off_y; end
            default: begin dx = -off_y; dy = -off_x; end
        endcase

        px = {{2{centre_x[8]}}, centre_x} + dx;
        py = {{3{centre_y[7]}}, centre_y} + dy;
        in_range = (px >= 11'sd0) && (px <= 11'sd255) && (py >= 11'sd0) && (py <= 11'sd127);

        // Sector tests compare dy^2 against 3*dx^2, i.e. |dy| vs sqrt(3)*|dx|
        // (the 60-degree boundary of each arc).  Screen y grows downwards.
        dx_w   = 22'(dx);
        dy_w   = 22'(dy);
        dx_sq3 = (dx_w * dx_w) * 22'sd3;
        dy_sq  = dy_w * dy_w;
        case (SEGMENT_TYPE)
            1:       in_seg = (dx <= 11'sd0) && (dy <= 11'sd0) && (dy_sq <= dx_sq3);
            2:       in_seg = (dx >= 11'sd0) && (dy <= 11'sd0) && (dy_sq <= dx_sq3);
            default: in_seg = (dy >= 11'sd0) && (dx_sq3 <= dy_sq);
        endcase

        state_next = state;
        case (state)
            E_IDLE:  if (start)   state_next = E_PLOT;
            E_PLOT:  if (finish)  state_next = E_FIN;
            E_FIN:   if (!start)  state_next = E_IDLE;
            default: state_next = E_IDLE;
        endcase

        done     = (state == E_FIN);
        vga_plot = (state == E_PLOT) && in_range && in_seg;
        vga_x    = px[7:0];
        vga_y    = py[6:0];
    end

endmodule

// File: rtl/reuleaux_centres.sv
// Combinational arc-centre calculation for the Reuleaux triangle.
//   centre_x/centre_y/diameter : triangle centre and side length
//   c1..c3 x/y                  : saturated signed arc centres
//     c1 = (cx+d/2, cy+h1), c2 = (cx-d/2, cy+h1), c3 = (cx, cy-h2)
module reuleaux_centres
    import reuleaux_pkg::*;
(
    input  logic        [7:0] centre_x,
    input  logic        [6:0] centre_y,
    input  logic        [7:0] diameter,
    output logic signed [8:0] c1_x,
    output logic signed [7:0] c1_y,
    output logic signed [8:0] c2_x,
    output logic signed [7:0] c2_y,
    output logic signed [8:0] c3_x,
    output logic signed [7:0] c3_y
);

    logic        [17:0] prod1, prod2;
    logic signed [10:0] cx, cy, half, h1, h2;

    always_comb begin
        prod1 = {10'd0, diameter} * 18'(K_SQ3_6);
        prod2 = {10'd0, diameter} * 18'(K_SQ3_3);
        cx    = $signed({3'b000, centre_x});
        cy    = $signed({4'b0000, centre_y});
        half  = $signed({4'b0000, diameter[7:1]});
        h1    = $signed(11'(prod1 >> K_SHIFT));
        h2    = $signed(11'(prod2 >> K_SHIFT));

        c1_x = sat_x(cx + half);
        c1_y = sat_y(cy + h1);
        c2_x = sat_x(cx - half);
        c2_y = sat_y(cy + h1);
        c3_x = sat_x(cx);
        c3_y = sat_y(cy - h2);
    end

endmodule

// File: rtl/reuleaux_ctrl.sv
// Reuleaux triangle draw sequencer.
// Optionally clears the screen to black, then runs three arc engines in turn
// and multiplexes the active pixel source onto the single VGA write port.
//   clk, rst_n : clock, asynchronous active-low reset (also resets the engines)
//   bus        : request inputs (start, centre, diameter, colour) and
//                done plus the VGA pixel-write port
module reuleaux_ctrl
    import reuleaux_pkg::*;
#(
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    reuleaux_if.slave  bus
);

    state_t             state, state_next;
    logic        [7:0]  clr_x;
    logic        [6:0]  clr_y;
    logic        [2:0]  colour_q;
    logic        [8:0]  radius_q;
    logic signed [8:0]  cen_x [3];
    logic signed [7:0]  cen_y [3];
    logic signed [8:0]  calc_x [3];
    logic signed [7:0]  calc_y [3];

    logic        [2:0]  eng_start, eng_done, eng_plot;
    logic        [7:0]  eng_x [3];
    logic        [6:0]  eng_y [3];

    logic               run_active;
    logic        [1:0]  run_idx;
    logic               clear_last;

    reuleaux_centres u_centres (
        .centre_x (bus.centre_x),
        .centre_y (bus.centre_y),
        .diameter (bus.diameter),
        .c1_x     (calc_x[0]),
        .c1_y     (calc_y[0]),
        .c2_x     (calc_x[1]),
        .c2_y     (calc_y[1]),
        .c3_x     (calc_x[2]),
        .c3_y     (calc_y[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_engine
        circle #(.SEGMENT_TYPE(g + 1)) u_circle (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (eng_start[g]),
            .centre_x (cen_x[g]),
            .centre_y (cen_y[g]),
            .radius   (radius_q),
            .done     (eng_done[g]),
            .vga_x    (eng_x[g]),
            .vga_y    (eng_y[g]),
            .vga_plot (eng_plot[g])
        );
    end

    assign clear_last = (clr_x == 8'(SCREEN_W - 1)) && (clr_y == 7'(SCREEN_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request parameters are captured once so the draw is immune to the
    // switches moving mid-sequence.  The clear counters rest at zero outside
    // CLEAR, which leaves them ready for the next draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_x    <= '0;
            clr_y    <= '0;
            colour_q <= '0;
            radius_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cen_x[i] <= '0;
                cen_y[i] <= '0;
            end
        end else begin
            if (state == LATCH) begin
                colour_q <= bus.colour;
                radius_q <= {1'b0, bus.diameter};
                for (int i = 0; i < 3; i++) begin
                    cen_x[i] <= calc_x[i];
                    cen_y[i] <= calc_y[i];
                end
            end
            if (state == CLEAR) begin
                if (clr_x == 8'(SCREEN_W - 1)) begin
                    clr_x <= '0;
                    clr_y <= clear_last ? 7'd0 : clr_y + 7'd1;
                end else begin
                    clr_x <= clr_x + 8'd1;
                end
            end else begin
                clr_x <= '0;
                clr_y <= '0;
            end
        end
    end

    // The pixel port is a pure mux of state, clear counters and the active
    // engine so engine pixels reach the VGA adapter with no added latency.
    always_comb begin
        state_next     = state;
        eng_start      = '0;
        run_active     = 1'b0;
        run_idx        = 2'd0;
        bus.done       = 1'b0;
        bus.vga_plot   = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;

        case (state)
            IDLE:   if (bus.start) state_next = LATCH;
            LATCH:  state_next = CLEAR_EN ? CLEAR : C1_RUN;
            CLEAR: begin
                bus.vga_plot = 1'b1;
                bus.vga_x    = clr_x;
                bus.vga_y    = clr_y;
                if (clear_last) state_next = C1_RUN;
            end
            C1_RUN: begin
                run_active = 1'b1;
                run_idx    = 2'd0;
                if (eng_done[0]) state_next = C1_ACK;
            end
            C1_ACK: state_next = C2_RUN;
            C2_RUN: begin
                run_active = 1'b1;
                run_idx    = 2'd1;
                if (eng_done[1]) state_next = C2_ACK;
            end
            C2_ACK: state_next = C3_RUN;
            C3_RUN: begin
                run_active = 1'b1;
                run_idx    = 2'd2;
                if (eng_done[2]) state_next = C3_ACK;
            end
            C3_ACK: state_next = DONE;
            DONE: begin
                bus.done = 1'b1;
                if (!bus.start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Engines may wander off the 160x120 frame; those pixels are dropped.
        if (run_active) begin
            eng_start[run_idx] = 1'b1;
            bus.vga_x          = eng_x[run_idx];
            bus.vga_y          = eng_y[run_idx];
            bus.vga_colour     = colour_q;
            bus.vga_plot       = eng_plot[run_idx]
                                 && (eng_x[run_idx] < 8'(SCREEN_W))
                                 && (eng_y[run_idx] < 7'(SCREEN_H));
        end
    end

endmodule
